// File: rtl/interface_output.sv
// Undoes the CORDIC input quadrant reduction on pipeline results and buffers them in a FWFT FIFO.
// Build option: INTERFACE_OUTPUT_SAT_EN enables saturation of out-of-range results and the ovf flag.
`timescale 1ns/1ps
module interface_output #(
  parameter int unsigned UNSIGNED_WIDTH    = 16,
  parameter int unsigned SECTOR_FLAG_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned FIFO_PTR_WIDTH    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [UNSIGNED_WIDTH-1:0]    degree_in,
  input  logic [UNSIGNED_WIDTH-1:0]    x_in,
  input  logic [UNSIGNED_WIDTH-1:0]    y_in,
  input  logic [SECTOR_FLAG_WIDTH-1:0] sector_in,
  input  logic                         arctan_en_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [UNSIGNED_WIDTH-1:0]    degree_out,
  output logic [UNSIGNED_WIDTH-1:0]    x_out,
  output logic [UNSIGNED_WIDTH-1:0]    y_out,
  output logic                         arctan_en_out,
  output logic                         ovf_out,
  output logic                         almost_full,
  output logic                         drop_err,
  output logic [FIFO_PTR_WIDTH:0]      fill_level
);

  localparam int unsigned W  = UNSIGNED_WIDTH;
  localparam int unsigned SW = SECTOR_FLAG_WIDTH;
  localparam int unsigned PW = FIFO_PTR_WIDTH;
  localparam int unsigned LW = FIFO_PTR_WIDTH + 1;
`ifdef INTERFACE_OUTPUT_SAT_EN
  // Two guard bits keep offset/negation results exact before clamping.
  localparam int unsigned CW = UNSIGNED_WIDTH + 2;
  localparam logic signed [CW-1:0] SMAX = CW'({(W-1){1'b1}});
  localparam logic signed [CW-1:0] SMIN = ~SMAX;
`else
  localparam int unsigned CW = UNSIGNED_WIDTH;
`endif
  localparam logic signed [CW-1:0] DEG90  = CW'(18'h05A00);
  localparam logic signed [CW-1:0] DEG180 = CW'(18'h0B400);

  typedef struct packed {
    logic         arctan;
    logic         ovf;
    logic [W-1:0] degree;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } entry_t;

  logic signed [CW-1:0] ed, ex, ey, rd, rx, ry;
  entry_t               corr;
  entry_t               stg;
  logic                 stg_valid;

  entry_t               mem [FIFO_DEPTH];
  entry_t               head, head_next;
  logic [PW-1:0]        wr_ptr, rd_ptr, wr_next, rd_next;
  logic [LW-1:0]        count, count_next;
  logic                 full, push, pop, drop;

  // Quadrant correction in the working width.
  always_comb begin
    ed = CW'($signed(degree_in));
    ex = CW'($signed(x_in));
    ey = CW'($signed(y_in));
    rd = ed;
    rx = ex;
    ry = ey;
    if (arctan_en_in) begin
      case (sector_in)
        SW'(1):  rd = ed + DEG90;
        SW'(2):  rd = ed - DEG180;
        SW'(3):  rd = ed - DEG90;
        default: rd = ed;
      endcase
    end else begin
      case (sector_in)
        SW'(1):  begin rx = -ey; ry = ex;  end
        SW'(2):  begin rx = -ex; ry = -ey; end
        SW'(3):  begin rx = ey;  ry = -ex; end
        default: begin rx = ex;  ry = ey;  end
      endcase
    end
  end

`ifdef INTERFACE_OUTPUT_SAT_EN
  function automatic logic [W:0] fit(input logic signed [CW-1:0] v);
    if (v > SMAX)      fit = {1'b1, SMAX[W-1:0]};
    else if (v < SMIN) fit = {1'b1, SMIN[W-1:0]};
    else               fit = {1'b0, v[W-1:0]};
  endfunction

  logic [W:0] fd, fx, fy;

  always_comb begin
    fd          = fit(rd);
    fx          = fit(rx);
    fy          = fit(ry);
    corr        = '0;
    corr.arctan = arctan_en_in;
    corr.ovf    = fd[W] | fx[W] | fy[W];
    corr.degree = fd[W-1:0];
    corr.x      = fx[W-1:0];
    corr.y      = fy[W-1:0];
  end
`else
  always_comb begin
    corr        = '0;
    corr.arctan = arctan_en_in;
    corr.ovf    = 1'b0;
    corr.degree = rd;
    corr.x      = rx;
    corr.y      = ry;
  end
`endif

  // Stage register; reset discards whatever is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= 1'b0;
      stg       <= '0;
    end else begin
      stg_valid <= valid_in;
      if (valid_in) stg <= corr;
    end
  end

  // FIFO control; a pop on a full FIFO frees the slot for a same-cycle push.
  always_comb begin
    full       = (count == LW'(FIFO_DEPTH));
    pop        = out_valid & out_ready;
    push       = stg_valid & (~full | pop);
    drop       = stg_valid & full & ~pop;
    count_next = count + LW'(push) - LW'(pop);
    rd_next    = rd_ptr + PW'(pop);
    wr_next    = wr_ptr + PW'(push);
    head_next  = '0;
    if (count_next != '0) begin
      if (push && (wr_ptr == rd_next)) head_next = stg;
      else                             head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      head        <= '0;
      out_valid   <= 1'b0;
      almost_full <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      wr_ptr      <= wr_next;
      rd_ptr      <= rd_next;
      count       <= count_next;
      head        <= head_next;
      out_valid   <= (count_next != '0);
      almost_full <= (count_next >= LW'(FIFO_DEPTH - 1));
      if (drop) drop_err <= 1'b1;
    end
  end

  assign degree_out    = head.degree;
  assign x_out         = head.x;
  assign y_out         = head.y;
  assign arctan_en_out = head.arctan;
  assign ovf_out       = head.ovf;
  assign fill_level    = count;

endmodule
